// File: rtl/md_pkg.sv
// Shared op codes, sequencer state encoding and op classification for the
// multiply/divide sequencer.
package md_pkg;

  localparam int unsigned MD_OPW = 4;

  typedef enum logic [MD_OPW-1:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MFHI    = 4'd7,
    MFLO    = 4'd8
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  function automatic logic is_muldiv(input logic [MD_OPW-1:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_div(input logic [MD_OPW-1:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Loadable down-counter that counts the remaining core latency.
// It saturates at zero and never wraps.
module md_lat_cnt #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/md_sched.sv
// Sequencer for the E-stage multiply/divide unit: starts the core, tracks
// latency, strobes HI/LO writes and stalls D on MD hazards.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  parameter int unsigned OPW     = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           issue_valid,
  input  logic [OPW-1:0] issue_op,
  input  logic           abort,
  input  logic           d_md_use,
  output logic           core_start,
  output logic [OPW-1:0] core_op,
  output logic           busy,
  output logic [1:0]     hilo_we,
  output logic           hilo_src,
  output logic           stall_d
);

  localparam int unsigned CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  md_state_e     state, state_nxt;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt, cnt_load_val;

  md_lat_cnt #(.CW(CW)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign cnt_load_val = is_div(issue_op) ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      core_op <= OPW'(MD_NONE);
    end else begin
      state <= state_nxt;
      if (core_start) begin
        core_op <= issue_op;
      end else if ((state == BUSY) && abort) begin
        core_op <= OPW'(MD_NONE);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    busy       = 1'b0;
    hilo_we    = 2'b00;
    hilo_src   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (issue_valid && !abort) begin
          if (is_muldiv(issue_op)) begin
            core_start = 1'b1;
            cnt_load   = 1'b1;
            state_nxt  = BUSY;
          end else if (issue_op == OPW'(MTHI)) begin
            hilo_we  = 2'b10;
            hilo_src = 1'b1;
          end else if (issue_op == OPW'(MTLO)) begin
            hilo_we  = 2'b01;
            hilo_src = 1'b1;
          end
        end
      end
      BUSY: begin
        busy = 1'b1;
        // Abort wins over a commit landing in the same (final) cycle.
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          hilo_we   = 2'b11;
          state_nxt = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_d = d_md_use && (busy || core_start);

endmodule

// File: tb/tb_md_sched.sv
// Randomized and directed checks of md_sched against a cycle-level
// reference model tracking the remaining busy cycles as a plain integer.
module tb_md_sched;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;
  localparam int unsigned OPW     = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           issue_valid;
  logic [OPW-1:0] issue_op;
  logic           abort;
  logic           d_md_use;
  logic           core_start;
  logic [OPW-1:0] core_op;
  logic           busy;
  logic [1:0]     hilo_we;
  logic           hilo_src;
  logic           stall_d;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // reference model: cycles of busy still to come (0 = idle) and latched op
  int unsigned    m_rem = 0;
  logic [OPW-1:0] m_op  = '0;
  int unsigned    busy_len;

  md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .OPW(OPW)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .abort       (abort),
    .d_md_use    (d_md_use),
    .core_start  (core_start),
    .core_op     (core_op),
    .busy        (busy),
    .hilo_we     (hilo_we),
    .hilo_src    (hilo_src),
    .stall_d     (stall_d)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      assert (!(busy && issue_valid)) else $error("issue while busy");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs at the falling edge, advance model.
  task automatic cycle(input logic v, input logic [OPW-1:0] op, input logic ab, input logic du);
    logic       e_start, e_busy, e_src;
    logic [1:0] e_we;
    issue_valid = v;
    issue_op    = op;
    abort       = ab;
    d_md_use    = du;
    @(negedge clk);
    e_busy  = (m_rem > 0);
    e_start = !e_busy && v && !ab && (op >= 1) && (op <= 4);
    e_we    = 2'b00;
    e_src   = 1'b0;
    if (e_busy && m_rem == 1 && !ab) e_we = 2'b11;
    if (!e_busy && v && !ab && op == 5) begin e_we = 2'b10; e_src = 1'b1; end
    if (!e_busy && v && !ab && op == 6) begin e_we = 2'b01; e_src = 1'b1; end
    check("core_start", 32'(core_start), 32'(e_start));
    check("busy",       32'(busy),       32'(e_busy));
    check("hilo_we",    32'(hilo_we),    32'(e_we));
    check("hilo_src",   32'(hilo_src),   32'(e_src));
    check("stall_d",    32'(stall_d),    32'(du && (e_busy || e_start)));
    check("core_op",    32'(core_op),    32'(m_op));
    if (e_busy) begin
      if (ab) begin m_rem = 0; m_op = '0; end
      else m_rem--;
    end else if (e_start) begin
      m_rem = (op >= 3) ? DIV_LAT : MUL_LAT;
      m_op  = op;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Issue an op and measure how many cycles busy stays high (bounded).
  task automatic measure_busy(input logic [OPW-1:0] op, output int unsigned len);
    len = 0;
    cycle(1'b1, op, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 40; i++) begin
      if (m_rem == 0) break;
      if (busy) len++;
      cycle(1'b0, '0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b0; issue_valid = 1'b0; issue_op = '0; abort = 1'b0; d_md_use = 1'b0;
    #12;
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_core_op", 32'(core_op), 32'd0);
    check("rst_hilo_we", 32'(hilo_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(2);

    measure_busy(4'd1, busy_len);
    check("mult_busy_len", busy_len, MUL_LAT);
    measure_busy(4'd3, busy_len);
    check("div_busy_len", busy_len, DIV_LAT);
    idle_cycles(1);

    cycle(1'b1, 4'd6, 1'b0, 1'b0);   // MTLO
    cycle(1'b1, 4'd5, 1'b0, 1'b1);   // MTHI
    cycle(1'b1, 4'd7, 1'b0, 1'b1);   // MFHI: no action
    cycle(1'b1, 4'd1, 1'b1, 1'b1);   // MULT with abort in issue cycle
    cycle(1'b1, 4'd6, 1'b1, 1'b0);   // MTLO with abort

    cycle(1'b1, 4'd4, 1'b0, 1'b0);   // DIVU, abort in 4th busy cycle
    idle_cycles(3);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle_cycles(2);

    cycle(1'b1, 4'd2, 1'b0, 1'b0);   // MULTU, abort on final busy cycle
    idle_cycles(MUL_LAT - 1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle_cycles(2);

    // asynchronous reset in the middle of a divide
    cycle(1'b1, 4'd3, 1'b0, 1'b1);
    idle_cycles(3);
    reset = 1'b0;
    #1;
    check("async_rst_busy",    32'(busy),    32'd0);
    check("async_rst_stall",   32'(stall_d), 32'd0);
    check("async_rst_core_op", 32'(core_op), 32'd0);
    m_rem = 0; m_op = '0;
    #2;
    reset = 1'b1;
    idle_cycles(DIV_LAT + 2);

    for (int unsigned i = 0; i < 3000; i++) begin
      logic           v, ab, du;
      logic [OPW-1:0] op;
      op = OPW'($urandom_range(0, 8));
      v  = (m_rem == 0) && ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 11) == 0);
      du = $urandom_range(0, 1) == 1;
      cycle(v, op, ab, du);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
